// File: rtl/rv64g_l2_pkg.sv
// Shared widths and FSM encoding for the L2 data/tag array controller.
package rv64g_l2_pkg;
  localparam int IDX_W  = 8;
  localparam int WAY_W  = 4;
  localparam int WORD_W = 3;
  localparam int TAG_W  = 50;
  localparam int DATA_W = 64;
  localparam int BE_W   = DATA_W / 8;

  typedef logic [1:0] l2_state_t;
  localparam l2_state_t ST_IDLE   = 2'd0;
  localparam l2_state_t ST_FILL   = 2'd1;
  localparam l2_state_t ST_EV_RD  = 2'd2;
  localparam l2_state_t ST_EV_OUT = 2'd3;
endpackage

// File: rtl/rv64g_l2_rr_arb2.sv
// Two-way round-robin arbiter between line fill and eviction requests.
module rv64g_l2_rr_arb2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req_fill_i,
  input  logic req_evict_i,
  output logic gnt_fill_o,
  output logic gnt_evict_o
);
  logic prio_evict_r;

  // A tie goes to whichever side was not granted last.
  always_comb begin
    gnt_fill_o  = en_i & req_fill_i & (~req_evict_i | ~prio_evict_r);
    gnt_evict_o = en_i & req_evict_i & (~req_fill_i | prio_evict_r);
  end

  // Priority moves to the loser of every grant; fill leads out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_evict_r <= 1'b0;
    end else if (gnt_fill_o) begin
      prio_evict_r <= 1'b1;
    end else if (gnt_evict_o) begin
      prio_evict_r <= 1'b0;
    end
  end
endmodule

// File: rtl/rv64g_l2_array_ctrl.sv
// L2 data/tag array sequencer: line fills and two-cycle-per-beat eviction reads.
// Define L2_ARRAY_CTRL_PERF_EN to add saturating line-completion counters.
module rv64g_l2_array_ctrl
  import rv64g_l2_pkg::*;
#(
  parameter int NBEATS = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fill_req_i,
  input  logic [IDX_W-1:0]  fill_index_i,
  input  logic [WAY_W-1:0]  fill_way_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  output logic              fill_gnt_o,
  input  logic              fill_valid_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output logic              fill_ready_o,
  input  logic              evict_req_i,
  input  logic [IDX_W-1:0]  evict_index_i,
  input  logic [WAY_W-1:0]  evict_way_i,
  output logic              evict_gnt_o,
  output logic              evict_valid_o,
  output logic [DATA_W-1:0] evict_data_o,
  output logic [TAG_W-1:0]  evict_tag_o,
  input  logic              evict_ready_i,
  output logic [IDX_W-1:0]  arr_index_o,
  output logic [WORD_W-1:0] arr_word_sel_o,
  output logic [WAY_W-1:0]  arr_way_sel_o,
  output logic              arr_write_en_o,
  output logic [BE_W-1:0]   arr_be_o,
  output logic [TAG_W-1:0]  arr_tag_o,
  output logic [DATA_W-1:0] arr_wdata_o,
  input  logic [DATA_W-1:0] arr_rdata_i,
  input  logic [TAG_W-1:0]  arr_tag_i,
  output logic              busy_o
`ifdef L2_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_fill_lines_o,
  output logic [31:0]       perf_evict_lines_o
`endif
);
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(NBEATS - 1);

  l2_state_t         state_r;
  logic [WORD_W-1:0] beat_r;
  logic [IDX_W-1:0]  index_r;
  logic [WAY_W-1:0]  way_r;
  logic [TAG_W-1:0]  tag_r;
  logic              fill_gnt_r;
  logic              evict_gnt_r;
  logic              gnt_fill_s;
  logic              gnt_evict_s;
  logic              last_beat_s;
  logic              fill_fire_s;
  logic              ev_fire_s;

  rv64g_l2_rr_arb2 u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (state_r == ST_IDLE),
    .req_fill_i  (fill_req_i),
    .req_evict_i (evict_req_i),
    .gnt_fill_o  (gnt_fill_s),
    .gnt_evict_o (gnt_evict_s)
  );

  assign last_beat_s = (beat_r == LAST_BEAT);
  assign fill_fire_s = (state_r == ST_FILL) && fill_valid_i;
  assign ev_fire_s   = (state_r == ST_EV_OUT) && evict_ready_i;
  assign fill_gnt_o  = fill_gnt_r;
  assign evict_gnt_o = evict_gnt_r;
  assign busy_o      = (state_r != ST_IDLE);

  // Sequencer state, beat counter and request latches; grants pulse on entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      beat_r      <= {WORD_W{1'b0}};
      index_r     <= {IDX_W{1'b0}};
      way_r       <= {WAY_W{1'b0}};
      tag_r       <= {TAG_W{1'b0}};
      fill_gnt_r  <= 1'b0;
      evict_gnt_r <= 1'b0;
    end else begin
      fill_gnt_r  <= 1'b0;
      evict_gnt_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (gnt_fill_s) begin
            state_r    <= ST_FILL;
            beat_r     <= {WORD_W{1'b0}};
            index_r    <= fill_index_i;
            way_r      <= fill_way_i;
            tag_r      <= fill_tag_i;
            fill_gnt_r <= 1'b1;
          end else if (gnt_evict_s) begin
            state_r     <= ST_EV_RD;
            beat_r      <= {WORD_W{1'b0}};
            index_r     <= evict_index_i;
            way_r       <= evict_way_i;
            tag_r       <= {TAG_W{1'b0}};
            evict_gnt_r <= 1'b1;
          end
        end
        ST_FILL: begin
          if (fill_valid_i) begin
            if (last_beat_s) begin
              state_r <= ST_IDLE;
              beat_r  <= {WORD_W{1'b0}};
            end else begin
              beat_r  <= beat_r + 3'd1;
            end
          end
        end
        ST_EV_RD: state_r <= ST_EV_OUT;
        ST_EV_OUT: begin
          if (evict_ready_i) begin
            if (last_beat_s) begin
              state_r <= ST_IDLE;
              beat_r  <= {WORD_W{1'b0}};
            end else begin
              state_r <= ST_EV_RD;
              beat_r  <= beat_r + 3'd1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Array and stream outputs decoded from state; everything is zero in IDLE.
  always_comb begin
    fill_ready_o   = 1'b0;
    evict_valid_o  = 1'b0;
    evict_data_o   = {DATA_W{1'b0}};
    evict_tag_o    = {TAG_W{1'b0}};
    arr_index_o    = {IDX_W{1'b0}};
    arr_word_sel_o = {WORD_W{1'b0}};
    arr_way_sel_o  = {WAY_W{1'b0}};
    arr_write_en_o = 1'b0;
    arr_be_o       = {BE_W{1'b0}};
    arr_tag_o      = {TAG_W{1'b0}};
    arr_wdata_o    = {DATA_W{1'b0}};
    case (state_r)
      ST_FILL: begin
        fill_ready_o   = 1'b1;
        arr_index_o    = index_r;
        arr_word_sel_o = beat_r;
        arr_way_sel_o  = way_r;
        arr_tag_o      = tag_r;
        if (fill_valid_i) begin
          arr_write_en_o = 1'b1;
          arr_be_o       = {BE_W{1'b1}};
          arr_wdata_o    = fill_data_i;
        end else begin
          arr_write_en_o = 1'b0;
        end
      end
      ST_EV_RD: begin
        arr_index_o    = index_r;
        arr_word_sel_o = beat_r;
        arr_way_sel_o  = way_r;
      end
      ST_EV_OUT: begin
        // Address stays put so the registered array keeps presenting this beat.
        arr_index_o    = index_r;
        arr_word_sel_o = beat_r;
        arr_way_sel_o  = way_r;
        evict_valid_o  = 1'b1;
        evict_data_o   = arr_rdata_i;
        evict_tag_o    = arr_tag_i;
      end
      default: begin
        fill_ready_o = 1'b0;
      end
    endcase
  end

`ifdef L2_ARRAY_CTRL_PERF_EN
  // Saturating counts of completed fill and eviction lines.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fill_lines_o  <= 32'd0;
      perf_evict_lines_o <= 32'd0;
    end else begin
      if (fill_fire_s && last_beat_s && (perf_fill_lines_o != 32'hFFFF_FFFF)) begin
        perf_fill_lines_o <= perf_fill_lines_o + 32'd1;
      end
      if (ev_fire_s && last_beat_s && (perf_evict_lines_o != 32'hFFFF_FFFF)) begin
        perf_evict_lines_o <= perf_evict_lines_o + 32'd1;
      end
    end
  end
`else
  logic unused_fire_s;
  assign unused_fire_s = fill_fire_s ^ ev_fire_s;
`endif
endmodule

// File: tb/tb_rv64g_l2_array_ctrl.sv
// Self-checking bench for rv64g_l2_array_ctrl with a registered-read array model.
module tb_rv64g_l2_array_ctrl;
  localparam int NB = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fill_req_i, fill_valid_i, evict_req_i, evict_ready_i;
  logic [7:0]  fill_index_i, evict_index_i;
  logic [3:0]  fill_way_i, evict_way_i;
  logic [49:0] fill_tag_i;
  logic [63:0] fill_data_i;
  logic        fill_gnt_o, fill_ready_o, evict_gnt_o, evict_valid_o;
  logic [63:0] evict_data_o;
  logic [49:0] evict_tag_o;
  logic [7:0]  arr_index_o;
  logic [2:0]  arr_word_sel_o;
  logic [3:0]  arr_way_sel_o;
  logic        arr_write_en_o;
  logic [7:0]  arr_be_o;
  logic [49:0] arr_tag_o;
  logic [63:0] arr_wdata_o;
  logic [63:0] arr_rdata_i;
  logic [49:0] arr_tag_i;
  logic        busy_o;
`ifdef L2_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_fill_lines_o, perf_evict_lines_o;
`endif

  int n_checks = 0;
  int n_pass = 0;
  int fills_done = 0;
  int evicts_done = 0;
  int n_arr_wr = 0;

  // Reference contents of every line the bench has filled, keyed by index/way/word.
  logic [63:0] ref_data [int];
  logic [49:0] ref_tag [int];
  int          lines [$];

  typedef struct {
    bit          is_fill;
    bit          seq;
    logic [7:0]  idx;
    logic [3:0]  way;
    logic [49:0] tag;
    int          stall_beat;
    int          stall_len;
    int          exp_cyc;
  } vec_t;
  vec_t tbl [6];

  always #5 clk_i = ~clk_i;

  rv64g_l2_array_ctrl #(.NBEATS(NB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .fill_req_i(fill_req_i), .fill_index_i(fill_index_i), .fill_way_i(fill_way_i),
    .fill_tag_i(fill_tag_i), .fill_gnt_o(fill_gnt_o),
    .fill_valid_i(fill_valid_i), .fill_data_i(fill_data_i), .fill_ready_o(fill_ready_o),
    .evict_req_i(evict_req_i), .evict_index_i(evict_index_i), .evict_way_i(evict_way_i),
    .evict_gnt_o(evict_gnt_o),
    .evict_valid_o(evict_valid_o), .evict_data_o(evict_data_o), .evict_tag_o(evict_tag_o),
    .evict_ready_i(evict_ready_i),
    .arr_index_o(arr_index_o), .arr_word_sel_o(arr_word_sel_o), .arr_way_sel_o(arr_way_sel_o),
    .arr_write_en_o(arr_write_en_o), .arr_be_o(arr_be_o), .arr_tag_o(arr_tag_o),
    .arr_wdata_o(arr_wdata_o), .arr_rdata_i(arr_rdata_i), .arr_tag_i(arr_tag_i),
    .busy_o(busy_o)
`ifdef L2_ARRAY_CTRL_PERF_EN
    , .perf_fill_lines_o(perf_fill_lines_o), .perf_evict_lines_o(perf_evict_lines_o)
`endif
  );

  // Array model: synchronous write, one-cycle registered read.
  logic [63:0] arr_mem [0:32767];
  logic [49:0] tag_mem [0:4095];
  always @(posedge clk_i) begin
    if (arr_write_en_o) begin
      arr_mem[{arr_index_o, arr_way_sel_o, arr_word_sel_o}] <= arr_wdata_o;
      tag_mem[{arr_index_o, arr_way_sel_o}] <= arr_tag_o;
      n_arr_wr <= n_arr_wr + 1;
    end
    arr_rdata_i <= arr_mem[{arr_index_o, arr_way_sel_o, arr_word_sel_o}];
    arr_tag_i   <= tag_mem[{arr_index_o, arr_way_sel_o}];
  end

  function automatic int lkey(logic [7:0] i, logic [3:0] w, int b);
    return (int'({i, w}) << 3) + b;
  endfunction

  function automatic logic [319:0] outs_vec();
    return {fill_gnt_o, fill_ready_o, evict_gnt_o, evict_valid_o, evict_data_o, evict_tag_o,
            arr_index_o, arr_word_sel_o, arr_way_sel_o, arr_write_en_o, arr_be_o, arr_tag_o,
            arr_wdata_o, busy_o};
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    fill_req_i = 1'b0; fill_valid_i = 1'b0; evict_req_i = 1'b0; evict_ready_i = 1'b0;
    fill_index_i = 8'd0; fill_way_i = 4'd0; fill_tag_i = 50'd0; fill_data_i = 64'd0;
    evict_index_i = 8'd0; evict_way_i = 4'd0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_outputs", outs_vec(), {320{1'b0}});
    rst_ni = 1'b1;
    step();
    chk("idle_outputs", outs_vec(), {320{1'b0}});
    fills_done = 0;
    evicts_done = 0;
  endtask

  task automatic do_fill(input logic [7:0] idx, input logic [3:0] way, input logic [49:0] tag,
                         input bit seq, input bit bubbles, output int busy_cyc);
    logic [63:0] d;
    int n;
    busy_cyc = 0;
    fill_index_i = idx; fill_way_i = way; fill_tag_i = tag;
    fill_valid_i = 1'b0; fill_req_i = 1'b1;
    n = 0;
    do begin step(); n++; end while (!fill_gnt_o && n < 100);
    chk("fill_grant", {fill_gnt_o, busy_o}, 2'b11);
    fill_req_i = 1'b0;
    // Scramble the request fields: the line must use the latched copy.
    fill_index_i = ~idx; fill_way_i = ~way; fill_tag_i = ~tag;
    for (int b = 0; b < NB; b++) begin
      d = seq ? 64'(b) * 64'd1111 : {$urandom, $urandom};
      if (bubbles && ($urandom_range(0, 2) == 0)) begin
        fill_valid_i = 1'b0;
        #1;
        chk("fill_bubble", {arr_write_en_o, fill_ready_o}, 2'b01);
        step();
        busy_cyc++;
      end
      fill_valid_i = 1'b1;
      fill_data_i = d;
      #1;
      chk("fill_beat", {fill_ready_o, arr_write_en_o, arr_be_o, arr_word_sel_o, arr_index_o,
                        arr_way_sel_o, arr_tag_o, arr_wdata_o},
          {1'b1, 1'b1, 8'hFF, 3'(b), idx, way, tag, d});
      ref_data[lkey(idx, way, b)] = d;
      step();
      busy_cyc++;
    end
    fill_valid_i = 1'b0;
    #1;
    chk("fill_done_idle", {busy_o, arr_write_en_o, fill_ready_o}, 3'b000);
    ref_tag[int'({idx, way})] = tag;
    lines.push_back(int'({idx, way}));
    fills_done++;
  endtask

  task automatic do_evict(input logic [7:0] idx, input logic [3:0] way, input int stall_beat,
                          input int stall_len, input bit rnd_stall, output int busy_cyc);
    logic [63:0] d;
    int n;
    int stalls;
    busy_cyc = 0;
    evict_index_i = idx; evict_way_i = way; evict_ready_i = 1'b0; evict_req_i = 1'b1;
    n = 0;
    do begin step(); n++; end while (!evict_gnt_o && n < 100);
    chk("evict_grant", {evict_gnt_o, busy_o}, 2'b11);
    evict_req_i = 1'b0;
    evict_index_i = ~idx; evict_way_i = ~way;
    for (int b = 0; b < NB; b++) begin
      d = ref_data[lkey(idx, way, b)];
      chk("evict_rd", {evict_gnt_o, evict_valid_o, arr_write_en_o, arr_index_o, arr_way_sel_o,
                       arr_word_sel_o}, {(b == 0), 1'b0, 1'b0, idx, way, 3'(b)});
      step();
      busy_cyc++;
      stalls = rnd_stall ? int'($urandom_range(0, 2)) : ((b == stall_beat) ? stall_len : 0);
      for (int s = 0; s < stalls; s++) begin
        evict_ready_i = 1'b0;
        #1;
        chk("evict_hold", {evict_valid_o, evict_data_o, arr_word_sel_o, arr_index_o},
            {1'b1, d, 3'(b), idx});
        step();
        busy_cyc++;
      end
      evict_ready_i = 1'b1;
      #1;
      chk("evict_beat", {evict_valid_o, evict_data_o, evict_tag_o, arr_word_sel_o, arr_write_en_o},
          {1'b1, d, ref_tag[int'({idx, way})], 3'(b), 1'b0});
      step();
      busy_cyc++;
      evict_ready_i = 1'b0;
    end
    #1;
    chk("evict_done_idle", {busy_o, evict_valid_o}, 2'b00);
    evicts_done++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int w0;
    int n;
    logic [11:0] code;

    tbl[0] = '{1'b1, 1'b1, 8'd10,  4'd5,  50'h123456789ABC,   0, 0,  8};
    tbl[1] = '{1'b0, 1'b0, 8'd10,  4'd5,  50'h0,             -1, 0, 16};
    tbl[2] = '{1'b0, 1'b0, 8'd10,  4'd5,  50'h0,              2, 3, 19};
    tbl[3] = '{1'b1, 1'b0, 8'hA7,  4'hC,  50'h3_DEAD_BEEF_CAFE, 0, 0,  8};
    tbl[4] = '{1'b0, 1'b0, 8'hA7,  4'hC,  50'h0,              0, 2, 18};
    tbl[5] = '{1'b0, 1'b0, 8'hA7,  4'hC,  50'h0,              7, 1, 17};

    apply_reset();

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].is_fill) do_fill(tbl[i].idx, tbl[i].way, tbl[i].tag, tbl[i].seq, 1'b0, cyc);
      else do_evict(tbl[i].idx, tbl[i].way, tbl[i].stall_beat, tbl[i].stall_len, 1'b0, cyc);
      chk("tbl_busy_cycles", cyc, tbl[i].exp_cyc);
    end

    for (int i = 0; i < 30; i++) begin
      if ((lines.size() == 0) || ($urandom_range(0, 1) == 0)) begin
        do_fill(8'($urandom_range(0, 127)), 4'($urandom), 50'({$urandom, $urandom}),
                1'b0, 1'b1, cyc);
      end else begin
        code = 12'(lines[$urandom_range(0, lines.size() - 1)]);
        do_evict(code[11:4], code[3:0], -1, 0, 1'b1, cyc);
      end
    end

    // Reset in the middle of a fill: beat 4 must never reach the array.
    w0 = n_arr_wr;
    fill_index_i = 8'd150; fill_way_i = 4'd3; fill_tag_i = 50'h1; fill_req_i = 1'b1;
    n = 0;
    do begin step(); n++; end while (!fill_gnt_o && n < 100);
    chk("rst_fill_grant", fill_gnt_o, 1'b1);
    fill_req_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      fill_valid_i = 1'b1;
      fill_data_i = 64'hF00 + 64'(b);
      step();
    end
    fill_data_i = 64'hBAD;
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_fill", {busy_o, arr_write_en_o, fill_ready_o}, 3'b000);
    step();
    chk("rst_no_extra_write", n_arr_wr - w0, 4);
    rst_ni = 1'b1;
    fills_done = 0;
    evicts_done = 0;
    step();
    chk("post_rst_idle", {busy_o, arr_write_en_o}, 2'b00);
    fill_valid_i = 1'b0;
    do_fill(8'd150, 4'd3, 50'h2_0000_0000_0155, 1'b0, 1'b0, cyc);
    chk("post_rst_fill_cycles", cyc, 8);
    do_evict(8'd150, 4'd3, -1, 0, 1'b0, cyc);

    // Both requesters held from reset: grants must alternate starting with fill.
    apply_reset();
    fill_index_i = 8'd200; fill_way_i = 4'd1; fill_tag_i = 50'h2A; fill_data_i = 64'h5555;
    evict_index_i = 8'd201; evict_way_i = 4'd2;
    fill_valid_i = 1'b1; evict_ready_i = 1'b1; fill_req_i = 1'b1; evict_req_i = 1'b1;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      do begin step(); n++; end while (!(fill_gnt_o || evict_gnt_o) && n < 100);
      chk("rr_grant_order", {fill_gnt_o, evict_gnt_o}, (g % 2 == 0) ? 2'b10 : 2'b01);
      if (g == 2) begin
        fill_req_i = 1'b0;
        evict_req_i = 1'b0;
      end
      n = 0;
      while (busy_o && n < 100) begin step(); n++; end
      chk("rr_line_done", busy_o, 1'b0);
      if (g % 2 == 0) fills_done++;
      else evicts_done++;
    end
    fill_valid_i = 1'b0;
    evict_ready_i = 1'b0;

`ifdef L2_ARRAY_CTRL_PERF_EN
    step();
    chk("perf_fill_lines", perf_fill_lines_o, fills_done);
    chk("perf_evict_lines", perf_evict_lines_o, evicts_done);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
